// File: rtl/sign_pos_counter_if.sv
// Record read port of the sign-bit position counter.
// master: the counter (record source); slave: the consumer popping records.
interface sign_pos_counter_if #(
   parameter int unsigned CNT_W = 7
);
   logic             cnt_rd_en;
   logic [CNT_W-1:0] cnt_out;
   logic             sign_flag_out;
   logic             extend_flag_out;
   logic             cnt_valid;
   logic             cnt_afull;

   modport master (
      input  cnt_rd_en,
      output cnt_out, sign_flag_out, extend_flag_out, cnt_valid, cnt_afull
   );

   modport slave (
      output cnt_rd_en,
      input  cnt_out, sign_flag_out, extend_flag_out, cnt_valid, cnt_afull
   );
endinterface

// File: rtl/sign_pos_counter.sv
// Sign-bit position counter: tracks bitstream position from VLD advance/align
// strobes and queues distance records (sign/extend/skip/terminator) in a FIFO.
module sign_pos_counter #(
   parameter int unsigned CNT_W        = 7,
   parameter int unsigned ADV_W        = 5,
   parameter int unsigned LOC_W        = 5,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned AFULL_MARGIN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic [ADV_W-1:0] advance,
   input  logic             align,
   input  logic             sign_en,
   input  logic             extend_en,
   input  logic [LOC_W-1:0] sign_loc,
   input  logic             slice_end,
   sign_pos_counter_if.master cnt_if,
   output logic             err
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = CNT_W + 1;
   localparam int unsigned RW = CNT_W + 2;
   // Wide enough for dist + advance + pad + sign_loc without overflow.
   localparam int unsigned SW = DW + ADV_W + LOC_W + 4;

   localparam logic [SW-1:0]    SKIP_W    = SW'(2**CNT_W - 1);
   localparam logic [CNT_W-1:0] SKIP_C    = '1;
   localparam logic [AW:0]      OCC_ONE   = (AW+1)'(1);
   localparam logic [AW:0]      OCC_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]      OCC_AFULL = (AW+1)'(DEPTH - AFULL_MARGIN);
   localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

   logic [DW-1:0]  dist_q, dist_d;
   logic [2:0]     phase_q, phase_d;
   logic           pend_q, pend_d;
   logic           err_q;

   logic [RW-1:0]  mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    occ_q;

   logic [SW-1:0]  adv_w, loc_w, pad_w, cnt_w, d_w;
   logic [2:0]     ph_a, pad;
   logic           wr_req, dist_err;
   logic [RW-1:0]  wr_rec;
   logic           rd_ok, wr_ok, ovf, full;
   logic [RW-1:0]  head;

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [SW-1:0] v);
      return (v > SKIP_W) ? SKIP_C : v[CNT_W-1:0];
   endfunction

   // Next-state position tracking and record generation for this cycle.
   always_comb begin
      adv_w    = SW'(advance);
      loc_w    = SW'(sign_loc);
      ph_a     = 3'(SW'(phase_q) + adv_w);
      pad      = align ? (3'd0 - ph_a) : 3'd0;
      pad_w    = SW'(pad);
      phase_d  = ph_a + pad;
      cnt_w    = SW'(dist_q) + loc_w;
      d_w      = SW'(dist_q) + adv_w + pad_w;
      dist_d   = dist_q;
      pend_d   = pend_q;
      wr_req   = 1'b0;
      wr_rec   = '0;
      dist_err = 1'b0;
      if (sign_en | extend_en) begin
         wr_req = 1'b1;
         wr_rec = {extend_en, sign_en, sat_cnt(cnt_w)};
         if (cnt_w > SKIP_W) dist_err = 1'b1;
         if (loc_w < adv_w) begin
            dist_d = DW'(adv_w - loc_w - SW'(1) + pad_w);
         end else begin
            dist_d   = DW'(pad_w);
            dist_err = 1'b1;
         end
         // A slice end on an event cycle defers its terminator by one cycle.
         if (slice_end) pend_d = 1'b1;
      end else if (slice_end | pend_q) begin
         wr_req = 1'b1;
         wr_rec = {2'b11, sat_cnt(d_w)};
         dist_d = '0;
         pend_d = 1'b0;
      end else if (d_w >= SKIP_W) begin
         wr_req = 1'b1;
         wr_rec = {2'b00, SKIP_C};
         dist_d = DW'(d_w - SKIP_W);
      end else begin
         dist_d = DW'(d_w);
      end
   end

   // FIFO handshake: reads on empty are ignored, writes on full are dropped.
   always_comb begin
      full  = (occ_q == OCC_FULL);
      rd_ok = cnt_if.cnt_rd_en & (occ_q != '0);
      wr_ok = wr_req & (~full | rd_ok);
      ovf   = wr_req & full & ~rd_ok;
   end

   // Position state, sticky error, FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         dist_q   <= '0;
         phase_q  <= '0;
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else if (clk_en) begin
         dist_q  <= dist_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         if (dist_err | ovf) err_q <= 1'b1;
         if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({wr_ok, rd_ok})
            2'b10:   occ_q <= occ_q + OCC_ONE;
            2'b01:   occ_q <= occ_q - OCC_ONE;
            default: occ_q <= occ_q;
         endcase
      end
   end

   // FIFO storage; contents are unreset and masked by cnt_valid at the head.
   always_ff @(posedge clk) begin
      if (!rst && clk_en && wr_ok) mem_q[wr_ptr_q] <= wr_rec;
   end

   assign head                   = mem_q[rd_ptr_q];
   assign cnt_if.cnt_valid       = (occ_q != '0);
   assign cnt_if.cnt_out         = cnt_if.cnt_valid ? head[CNT_W-1:0] : '0;
   assign cnt_if.sign_flag_out   = cnt_if.cnt_valid & head[CNT_W];
   assign cnt_if.extend_flag_out = cnt_if.cnt_valid & head[CNT_W+1];
   assign cnt_if.cnt_afull       = (occ_q >= OCC_AFULL);
   assign err                    = err_q;
endmodule

// File: tb/tb_sign_pos_counter.sv
// Bench for sign_pos_counter: directed vector table, hand sequences for
// fill/overflow, clk_en freeze and mid-run reset, then random stimulus
// against an absolute-bit-position reference model.
module tb_sign_pos_counter;
   localparam int unsigned CNT_W = 7;
   localparam int unsigned DEPTH = 16;
   localparam longint      SKIP  = 127;

   logic       clk = 1'b0;
   logic       rst, clk_en, align, sign_en, extend_en, slice_end, err;
   logic [4:0] advance, sign_loc;

   int checks = 0;
   int errors = 0;

   sign_pos_counter_if #(.CNT_W(CNT_W)) cif ();

   sign_pos_counter #(
      .CNT_W(CNT_W), .ADV_W(5), .LOC_W(5), .DEPTH(DEPTH), .AFULL_MARGIN(4)
   ) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .advance(advance), .align(align),
      .sign_en(sign_en), .extend_en(extend_en), .sign_loc(sign_loc),
      .slice_end(slice_end), .cnt_if(cif), .err(err)
   );

   always #5 clk = ~clk;

   // Reference model: absolute bit positions instead of a running distance.
   longint     m_pos, m_last;
   bit         m_pend, m_err;
   logic [8:0] mq[$];

   function automatic logic [6:0] msat(input longint v);
      return (v > SKIP) ? 7'(SKIP) : 7'(v);
   endfunction

   function automatic void model_step(input logic r, ce, input int a, input logic aln,
                                      sg, ex, input int loc, input logic se, rd);
      longint     pnew, cnt, d;
      bit         wr, rd_ok;
      logic [8:0] rec;
      if (r) begin
         m_pos = 0; m_last = 0; m_pend = 0; m_err = 0; mq.delete();
         return;
      end
      if (!ce) return;
      wr = 0; rec = '0;
      pnew = m_pos + a;
      if (aln) pnew = ((pnew + 7) / 8) * 8;
      if (sg || ex) begin
         cnt = m_pos + loc - m_last;
         if (cnt > SKIP) m_err = 1;
         rec = {ex, sg, msat(cnt)};
         wr = 1;
         if (loc < a) m_last = m_pos + loc + 1;
         else begin m_last = m_pos + a; m_err = 1; end
         if (se) m_pend = 1;
      end else begin
         d = pnew - m_last;
         if (se || m_pend) begin
            rec = {2'b11, msat(d)}; wr = 1; m_last = pnew; m_pend = 0;
         end else if (d >= SKIP) begin
            rec = {2'b00, 7'(SKIP)}; wr = 1; m_last = m_last + SKIP;
         end
      end
      m_pos = pnew;
      rd_ok = rd && (mq.size() > 0);
      if (rd_ok) void'(mq.pop_front());
      if (wr) begin
         if (mq.size() == DEPTH) m_err = 1;
         else mq.push_back(rec);
      end
   endfunction

   task automatic cycle(input logic r, ce, input int a, input logic aln, sg, ex,
                        input int loc, input logic se, rd);
      rst = r; clk_en = ce; advance = 5'(a); align = aln; sign_en = sg;
      extend_en = ex; sign_loc = 5'(loc); slice_end = se; cif.cnt_rd_en = rd;
      model_step(r, ce, a, aln, sg, ex, loc, se, rd);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] dut_head();
      return {cif.extend_flag_out, cif.sign_flag_out, cif.cnt_out};
   endfunction

   typedef struct {
      logic       r;
      logic [4:0] adv;
      logic       aln, sg, ex;
      logic [4:0] loc;
      logic       se, rd;
      logic       e_valid;
      logic [6:0] e_cnt;
      logic       e_sgn, e_ext, e_afull, e_err;
   } vec_t;

   function automatic vec_t V(input logic r, input int adv, input logic aln, sg, ex,
                              input int loc, input logic se, rd, ev, input int ec,
                              input logic es, ee, ea, er);
      vec_t v;
      v.r = r; v.adv = 5'(adv); v.aln = aln; v.sg = sg; v.ex = ex; v.loc = 5'(loc);
      v.se = se; v.rd = rd; v.e_valid = ev; v.e_cnt = 7'(ec); v.e_sgn = es;
      v.e_ext = ee; v.e_afull = ea; v.e_err = er;
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      int   exp_q[$];
      bit   fill;
      int   a, loc;
      logic r, ce, aln, sg, ex, se, rd;

      rst = 1'b1; clk_en = 1'b1; advance = '0; align = 0; sign_en = 0;
      extend_en = 0; sign_loc = '0; slice_end = 0; cif.cnt_rd_en = 0;
      m_pos = 0; m_last = 0; m_pend = 0; m_err = 0;

      //             r adv aln sg ex loc se rd | ev cnt sg ex af er
      tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0, 5, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0, 5, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0, 5, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0, 4, 0, 1, 0, 2, 0, 0,   1, 17, 1, 0, 0, 0));
      tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0,   1, 17, 1, 0, 0, 0));
      tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0,   1, 17, 1, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 1,   1,  6, 1, 1, 0, 0));
      tbl.push_back(V(0,10, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0, 3, 0, 1, 1, 0, 1, 0,   1, 10, 1, 1, 0, 0));
      tbl.push_back(V(0, 4, 0, 0, 0, 0, 0, 1,   1,  6, 1, 1, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0, 3, 0, 0, 1, 1, 0, 0,   1,  1, 0, 1, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(V(0, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(V(0,31, 0, 0, 0, 0, 0, 0,   1,127, 0, 0, 0, 0));
      tbl.push_back(V(0,31, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0,31, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0,31, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0,31, 0, 0, 0, 0, 0, 0,   1,127, 0, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 0,   1, 25, 1, 1, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(V(0, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(V(0,20, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0));
      tbl.push_back(V(0,31, 0, 1, 0,30, 0, 0,   1,127, 1, 0, 0, 1));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 0, 1));

      foreach (tbl[i]) begin
         cycle(tbl[i].r, 1, tbl[i].adv, tbl[i].aln, tbl[i].sg, tbl[i].ex,
               tbl[i].loc, tbl[i].se, tbl[i].rd);
         chk($sformatf("tbl%0d valid", i), cif.cnt_valid, tbl[i].e_valid);
         if (tbl[i].e_valid)
            chk($sformatf("tbl%0d head", i), dut_head(),
                {tbl[i].e_ext, tbl[i].e_sgn, tbl[i].e_cnt});
         chk($sformatf("tbl%0d afull", i), cif.cnt_afull, tbl[i].e_afull);
         chk($sformatf("tbl%0d err", i), err, tbl[i].e_err);
      end

      // Fill to DEPTH without reads, overflow, then read+write while full.
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         cycle(0, 1, k, 0, 0, 0, 0, 1, 0);
         chk($sformatf("fill%0d afull", k), cif.cnt_afull, (k >= 12));
         chk($sformatf("fill%0d head", k), dut_head(), {2'b11, 7'd1});
         chk($sformatf("fill%0d err", k), err, 0);
      end
      cycle(0, 1, 17, 0, 0, 0, 0, 1, 0);
      chk("ovf err", err, 1);
      chk("ovf afull", cif.cnt_afull, 1);
      cycle(0, 1, 18, 0, 0, 0, 0, 1, 1);
      chk("rdwr full afull", cif.cnt_afull, 1);
      for (int k = 2; k <= 16; k++) exp_q.push_back(k);
      exp_q.push_back(18);
      foreach (exp_q[i]) begin
         chk($sformatf("drain%0d valid", i), cif.cnt_valid, 1);
         chk($sformatf("drain%0d head", i), dut_head(), {2'b11, 7'(exp_q[i])});
         cycle(0, 1, 0, 0, 0, 0, 0, 0, 1);
      end
      chk("drained valid", cif.cnt_valid, 0);
      chk("drained err sticky", err, 1);

      // Reset in the middle of filling discards contents and clears err.
      for (int k = 0; k < 3; k++) cycle(0, 1, 3, 0, 0, 0, 0, 1, 0);
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("midrst valid", cif.cnt_valid, 0);
      chk("midrst err", err, 0);
      chk("midrst afull", cif.cnt_afull, 0);
      cycle(0, 1, 5, 0, 0, 0, 0, 1, 0);
      chk("postrst head", dut_head(), {2'b11, 7'd5});

      // clk_en low freezes position, FIFO and reads.
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 7, 0, 1, 0, 1, 0, 1);
         chk($sformatf("frz%0d valid", k), cif.cnt_valid, 1);
         chk($sformatf("frz%0d head", k), dut_head(), {2'b11, 7'd5});
      end
      cycle(0, 1, 0, 0, 0, 0, 0, 1, 1);
      chk("unfrz head", dut_head(), {2'b11, 7'd0});
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 1);
      chk("unfrz empty", cif.cnt_valid, 0);

      // Random traffic against the reference model.
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 4000; n++) begin
         fill = ((n / 200) % 2) == 0;
         r   = ($urandom_range(0, 599) == 0);
         ce  = ($urandom_range(0, 9) != 0);
         a   = $urandom_range(0, 31);
         aln = ($urandom_range(0, 7) == 0);
         se  = ($urandom_range(0, 15) == 0);
         rd  = ($urandom_range(0, 99) < (fill ? 20 : 70));
         sg = 0; ex = 0; loc = 0;
         if ($urandom_range(0, 99) < (fill ? 60 : 25)) begin
            sg = $urandom_range(0, 1);
            ex = sg ? logic'($urandom_range(0, 1)) : 1'b1;
            if (a == 0) a = 1;
            loc = ($urandom_range(0, 199) == 0) ? $urandom_range(a, 31)
                                                : $urandom_range(0, a - 1);
         end
         cycle(r, ce, a, aln, sg, ex, loc, se, rd);
         chk("rnd valid", cif.cnt_valid, (mq.size() > 0));
         chk("rnd afull", cif.cnt_afull, (mq.size() >= 12));
         chk("rnd err", err, m_err);
         if (mq.size() > 0) chk("rnd head", dut_head(), mq[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sign_pos_counter.md
Name: sign_pos_counter

Overview:
- Parametrised successor of the sign-bit counter that sits between the VLD and the sign-bit extraction stage.
- Tracks the bitstream position from the VLD's registered advance/align strobes.
- Each marked sign or escape-extension bit produces a record containing the distance since the previously recorded bit. Records are written into an internal FIFO with an almost-full flag, which feeds the getbits stall logic.
- New over the previous generation: configurable widths and depth, skip records for long gaps, slice-end terminator records, and a sticky error flag.

Parameters:
- CNT_W, 7, record distance width; SKIP = 2^CNT_W-1
- ADV_W, 5, advance width
- LOC_W, 5, sign_loc width
- DEPTH, 16, FIFO entries (power of 2); AW = log2(DEPTH)
- AFULL_MARGIN, 4, afull asserted when occupancy >= DEPTH-AFULL_MARGIN

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  global enable; low freezes all state (including reads)
- advance  in  ADV_W  bits consumed this cycle
- align  in  1  advance to next byte boundary
- sign_en  in  1  bit at sign_loc in current window is a sign bit
- extend_en  in  1  bit at sign_loc is an escape/extend marker (may coincide with sign_en)
- sign_loc  in  LOC_W  offset of marked bit within current advance window; valid when sign_en|extend_en
- slice_end  in  1  emit terminator record
- cnt_rd_en  in  1  pop FIFO head
- cnt_out  out  CNT_W  head record distance
- sign_flag_out  out  1  head record sign flag
- extend_flag_out  out  1  head record extend flag
- cnt_valid  out  1  FIFO not empty
- cnt_afull  out  1  almost full
- err  out  1  sticky: distance saturation or FIFO overflow

Behaviour:
- Reset: dist=0, phase=0, pend_end=0, FIFO empty, cnt_valid=0, cnt_afull=0, err=0, cnt_out/flags=0.
- All updates require clk_en=1.
- State: dist (CNT_W+1 bits, bits since the end of the last recorded bit); phase (3 bits, total bits consumed mod 8).
- Per cycle: a = advance. If align, pad = (8-((phase+a) mod 8)) mod 8, else pad = 0. phase_next = (phase+a+pad) mod 8.
- Event cycle (sign_en|extend_en):
  - cnt = dist + sign_loc.
  - Write record {extend_en, sign_en, min(cnt, SKIP)}.
  - If cnt > SKIP, set err.
  - dist_next = a - sign_loc - 1 + pad. sign_loc < a is guaranteed by the VLD; if violated, dist_next = pad and err is set.
- Non-event cycle: d = dist + a + pad.
  - If slice_end or pend_end: write {1,1,min(d,SKIP)}, dist_next = 0, pend_end cleared.
  - Else if d >= SKIP: write skip record {0,0,SKIP}, dist_next = d - SKIP.
  - Else: dist_next = d, no write.
- slice_end coinciding with an event: the event record is written and pend_end is set, so the terminator is written the next cycle. In that next cycle the terminator distance includes that cycle's advance.
- At most one FIFO write per cycle.
- FIFO, registered-head first-word-fall-through:
  - Head outputs are valid while cnt_valid=1.
  - Read and write in the same cycle are both honoured; occupancy unchanged.
  - Read when empty is ignored.
  - Write when full (occupancy = DEPTH and no read that cycle): the write is dropped and err is set.
  - Write latency: record visible at head 1 cycle after the write cycle when the FIFO was empty.
  - cnt_afull is combinational from occupancy, updated the same cycle occupancy changes.
- err clears only on rst.
- Reset mid-operation: all state is cleared and FIFO contents are discarded on the reset edge.

Test Plan:
- Reset, advance=5 for 3 cycles, then sign_en with sign_loc=2, advance=4 -> one record {ext=0,sgn=1,cnt=17}; dist=1, phase=3; cnt_valid high the next cycle.
- From that state, align with advance=0 -> pad=5, dist=6, phase=0, no write. A second align -> pad=0, unchanged.
- Reset, advance=31 every cycle, no events -> cycle 5 writes {0,0,127}, dist=28. Cycle 9 (d=152) writes a second skip record {0,0,127}, dist=25.
- sign_en+extend_en+slice_end in the same cycle with dist=10, sign_loc=0, advance=3 -> record {1,1,10}, dist=2. The next cycle with advance=4 writes terminator {1,1,6}, dist=0.
- Fill with 16 records and no reads -> cnt_afull asserts at 12. The 17th write is dropped and err=1. A read+write in the same cycle keeps occupancy at 16.
- clk_en=0 with advance=7, sign_en and cnt_rd_en held -> no state change, no write, no pop. rst asserted mid-fill -> cnt_valid=0 and err=0 the next cycle.
